// File: rtl/uartlite_axi_responder.sv
// AXI4-lite slave model of the UART Lite register file: RX/TX byte FIFOs, STAT and CTRL.
// Optional `UARTLITE_RESPONDER_INTR_EN adds an intr pulse output.
module uartlite_axi_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int TX_GAP     = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  input  logic        rx_in_valid,
  input  logic [7:0]  rx_in_data,
  output logic        tx_out_valid,
  output logic [7:0]  tx_out_data,
  input  logic        tx_out_ready
`ifdef UARTLITE_RESPONDER_INTR_EN
  ,
  output logic        intr
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(TX_GAP + 2);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic        aw_held, w_held;
  logic [31:0] awaddr_q;
  logic [7:0]  wdata_q;
  logic        aw_fire, w_fire, wr_go, wr_err;
  logic [31:0] wr_addr;
  logic [7:0]  wr_byte;
  logic        tx_wr, ctrl_wr;

  logic        ar_fire, rd_err, stat_rd;
  logic [1:0]  rd_sel;
  logic [31:0] rd_val;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_clr;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_clr;
  logic [GW-1:0] gap;

  logic overrun, intr_en;

  logic unused_bits;
  assign unused_bits = ^{axi_awprot, axi_arprot, axi_wstrb, axi_wdata[31:8],
                         axi_awaddr[1:0], axi_araddr[1:0]};

  // Write channel: AW and W may arrive in either order; the write fires once both are present.
  assign aw_fire = axi_awvalid && axi_awready;
  assign w_fire  = axi_wvalid && axi_wready;
  assign wr_addr = aw_held ? awaddr_q : axi_awaddr;
  assign wr_byte = w_held ? wdata_q : axi_wdata[7:0];
  assign wr_go   = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_err  = wr_addr[31:4] != 28'd0;
  assign tx_wr   = wr_go && !wr_err && (wr_addr[3:2] == 2'd1);
  assign ctrl_wr = wr_go && !wr_err && (wr_addr[3:2] == 2'd3);

  always_ff @(posedge clk) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (wr_go) w_state_nxt = W_RESP;
      W_RESP:  if (axi_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    axi_awready = (w_state == W_IDLE) && !aw_held;
    axi_wready  = (w_state == W_IDLE) && !w_held;
    axi_bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      axi_bresp <= 2'b00;
    end else begin
      if (wr_go) begin
        aw_held   <= 1'b0;
        w_held    <= 1'b0;
        axi_bresp <= wr_err ? 2'b10 : 2'b00;
      end else begin
        if (aw_fire) begin
          aw_held  <= 1'b1;
          awaddr_q <= axi_awaddr;
        end
        if (w_fire) begin
          w_held  <= 1'b1;
          wdata_q <= axi_wdata[7:0];
        end
      end
    end
  end

  // Read channel: side effects (RX pop, overrun clear) happen at the AR handshake.
  assign ar_fire = axi_arvalid && axi_arready;
  assign rd_err  = axi_araddr[31:4] != 28'd0;
  assign rd_sel  = axi_araddr[3:2];
  assign stat_rd = ar_fire && !rd_err && (rd_sel == 2'd2);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
      R_DATA:  if (axi_rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    axi_arready = (r_state == R_IDLE);
    axi_rvalid  = (r_state == R_DATA);
  end

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      2'd0:    rd_val = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
      2'd2:    rd_val = {26'd0, overrun, intr_en, tx_full, tx_empty, rx_full, !rx_empty};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      axi_rdata <= '0;
      axi_rresp <= 2'b00;
    end else if (ar_fire) begin
      axi_rdata <= rd_err ? 32'd0 : rd_val;
      axi_rresp <= rd_err ? 2'b10 : 2'b00;
    end
  end

  // RX FIFO: a pop frees a slot for a same-cycle push; a clear beats everything.
  assign rx_full  = (rx_cnt == DEPTH_C);
  assign rx_empty = (rx_cnt == '0);
  assign rx_clr   = ctrl_wr && wr_byte[1];
  assign rx_pop   = ar_fire && !rd_err && (rd_sel == 2'd0) && !rx_empty;
  assign rx_push  = rx_in_valid && (!rx_full || rx_pop) && !rx_clr;

  always_comb begin
    rx_cnt_nxt = rx_cnt;
    if (rx_clr)                rx_cnt_nxt = '0;
    else if (rx_push && !rx_pop) rx_cnt_nxt = rx_cnt + 1'b1;
    else if (!rx_push && rx_pop) rx_cnt_nxt = rx_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn || rx_clr) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_in_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn)                                                overrun <= 1'b0;
    else if (rx_in_valid && rx_full && !rx_pop && !rx_clr)    overrun <= 1'b1;
    else if (stat_rd)                                         overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn)        intr_en <= 1'b0;
    else if (ctrl_wr) intr_en <= wr_byte[4];
  end

  // TX FIFO: head is offered only after the inter-byte gap has elapsed.
  assign tx_full      = (tx_cnt == DEPTH_C);
  assign tx_empty     = (tx_cnt == '0);
  assign tx_clr       = ctrl_wr && wr_byte[0];
  assign tx_push      = tx_wr && !tx_full && !tx_clr;
  assign tx_out_valid = !tx_empty && (gap == '0);
  assign tx_out_data  = tx_mem[tx_rp];
  assign tx_pop       = tx_out_valid && tx_out_ready && !tx_clr;

  always_comb begin
    tx_cnt_nxt = tx_cnt;
    if (tx_clr)                  tx_cnt_nxt = '0;
    else if (tx_push && !tx_pop) tx_cnt_nxt = tx_cnt + 1'b1;
    else if (!tx_push && tx_pop) tx_cnt_nxt = tx_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn || tx_clr) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (!rstn)          gap <= '0;
    else if (tx_pop)    gap <= GW'(TX_GAP);
    else if (gap != '0) gap <= gap - 1'b1;
  end

`ifdef UARTLITE_RESPONDER_INTR_EN
  always_ff @(posedge clk) begin
    if (!rstn) intr <= 1'b0;
    else       intr <= intr_en && ((rx_empty && (rx_cnt_nxt != '0)) ||
                                   (tx_pop && (tx_cnt_nxt == '0)));
  end
`endif

endmodule

// File: tb/tb_uartlite_axi_responder.sv
// Randomized bench for uartlite_axi_responder against a queue-based register-file model.
module tb_uartlite_axi_responder;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        axi_awvalid = 1'b0, axi_awready;
  logic [31:0] axi_awaddr = '0;
  logic [2:0]  axi_awprot = '0;
  logic        axi_wvalid = 1'b0, axi_wready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_bvalid, axi_bready = 1'b0;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid = 1'b0, axi_arready;
  logic [31:0] axi_araddr = '0;
  logic [2:0]  axi_arprot = '0;
  logic        axi_rvalid, axi_rready = 1'b0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        rx_in_valid = 1'b0;
  logic [7:0]  rx_in_data = '0;
  logic        tx_out_valid;
  logic [7:0]  tx_out_data;
  logic        tx_out_ready = 1'b0;

  uartlite_axi_responder #(.FIFO_DEPTH(DEPTH), .TX_GAP(GAP)) dut (
    .clk(clk), .rstn(rstn),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .rx_in_valid(rx_in_valid), .rx_in_data(rx_in_data),
    .tx_out_valid(tx_out_valid), .tx_out_data(tx_out_data), .tx_out_ready(tx_out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         m_ovr = 1'b0;
  bit         m_ien = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_stat();
    return {26'd0, m_ovr, m_ien, tx_q.size() == DEPTH, tx_q.size() == 0,
            rx_q.size() == DEPTH, rx_q.size() != 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] d);
    rx_in_valid = 1'b1;
    rx_in_data  = d;
    tick();
    rx_in_valid = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(d);
    else m_ovr = 1'b1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    axi_arvalid = 1'b1;
    axi_araddr  = addr;
    while (!axi_arready && n < 20) begin
      tick();
      n++;
    end
    if (!axi_arready) begin
      check("ar_timeout", {31'd0, axi_arready}, 32'd1);
      axi_arvalid = 1'b0;
      data = '0;
      resp = '0;
      return;
    end
    tick();
    axi_arvalid = 1'b0;
    check("rvalid_latency", {31'd0, axi_rvalid}, 32'd1);
    repeat ($urandom_range(0, 2)) tick();
    data = axi_rdata;
    resp = axi_rresp;
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check("rvalid_drop", {31'd0, axi_rvalid}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr);
    logic [31:0] got_d, exp_d;
    logic [1:0]  got_r, exp_r;
    axi_read(addr, got_d, got_r);
    exp_r = (addr[31:4] != 28'd0) ? 2'b10 : 2'b00;
    exp_d = '0;
    if (exp_r == 2'b00) begin
      case (addr[3:2])
        2'd0: if (rx_q.size() != 0) exp_d = {24'd0, rx_q.pop_front()};
        2'd2: begin exp_d = exp_stat(); m_ovr = 1'b0; end
        default: exp_d = '0;
      endcase
    end
    check({tag, "_resp"}, {30'd0, got_r}, {30'd0, exp_r});
    if (exp_r == 2'b00) check({tag, "_data"}, got_d, exp_d);
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input int daw, input int dw);
    int c = 0;
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    logic [1:0] exp_r;
    while (!(aw_done && w_done) && c < 40) begin
      if (c == daw) begin axi_awvalid = 1'b1; axi_awaddr = addr; end
      if (c == dw)  begin axi_wvalid = 1'b1;  axi_wdata = data; end
      aw_hs = axi_awvalid && axi_awready;
      w_hs  = axi_wvalid && axi_wready;
      tick();
      if (aw_hs) begin axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin axi_wvalid = 1'b0;  w_done = 1'b1; end
      if (aw_done && !w_done) check({tag, "_awready_held"}, {31'd0, axi_awready}, 32'd0);
      if (w_done && !aw_done) check({tag, "_wready_held"}, {31'd0, axi_wready}, 32'd0);
      c++;
    end
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    check({tag, "_handshakes"}, {30'd0, aw_done, w_done}, 32'd3);
    check({tag, "_bvalid"}, {31'd0, axi_bvalid}, 32'd1);
    exp_r = (addr[31:4] != 28'd0) ? 2'b10 : 2'b00;
    check({tag, "_bresp"}, {30'd0, axi_bresp}, {30'd0, exp_r});
    repeat ($urandom_range(0, 1)) tick();
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    check({tag, "_bdone"}, {30'd0, axi_bvalid, axi_awready && axi_wready}, 32'd1);
    if (exp_r == 2'b00) begin
      if (addr[3:2] == 2'd1 && tx_q.size() < DEPTH) tx_q.push_back(data[7:0]);
      if (addr[3:2] == 2'd3) begin
        if (data[0]) tx_q.delete();
        if (data[1]) rx_q.delete();
        m_ien = data[4];
      end
    end
  endtask

  task automatic drain_tx();
    int lows = -1;
    int n = 0;
    tx_out_ready = 1'b1;
    while (tx_q.size() != 0 && n < 300) begin
      if (tx_out_valid) begin
        check("tx_data", {24'd0, tx_out_data}, {24'd0, tx_q.pop_front()});
        if (lows >= 0) check("tx_gap", lows, GAP);
        lows = 0;
      end else if (lows >= 0) begin
        lows++;
      end
      tick();
      n++;
    end
    tx_out_ready = 1'b0;
    check("tx_drained", tx_q.size(), 0);
    check("tx_valid_when_empty", {31'd0, tx_out_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    repeat (3) tick();
    check("rst_readys", {29'd0, axi_awready, axi_wready, axi_arready}, 32'd7);
    check("rst_valids", {29'd0, axi_bvalid, axi_rvalid, tx_out_valid}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    check("rst_resps", {28'd0, axi_bresp, axi_rresp}, 32'd0);
    rstn = 1'b1;
    tick();

    rd_chk("stat_reset", 32'h8);

    push_rx(8'h41);
    push_rx(8'h42);
    rd_chk("rx_first", 32'h0);
    rd_chk("rx_second", 32'h0);
    rd_chk("stat_rx_drained", 32'h8);

    wr_chk("tx_w_first", 32'h4, 32'h5A, 3, 0);
    wr_chk("tx_second", 32'h4, 32'hA5, 0, 0);
    drain_tx();

    for (int i = 0; i < DEPTH + 1; i++) push_rx(8'($urandom));
    rd_chk("stat_overrun", 32'h8);
    rd_chk("stat_ovr_cleared", 32'h8);

    // Full RX: push and pop in the same cycle, no overrun.
    d = 8'($urandom);
    axi_arvalid = 1'b1; axi_araddr = 32'h0;
    rx_in_valid = 1'b1; rx_in_data = d;
    tick();
    axi_arvalid = 1'b0; rx_in_valid = 1'b0;
    check("full_pushpop_rvalid", {31'd0, axi_rvalid}, 32'd1);
    check("full_pushpop_data", axi_rdata, {24'd0, rx_q.pop_front()});
    rx_q.push_back(d);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    rd_chk("stat_full_pushpop", 32'h8);
    for (int i = 0; i < DEPTH; i++) rd_chk("rx_drain", 32'h0);
    rd_chk("rx_empty_read", 32'h0);

    // RX clear in the same cycle as a push.
    push_rx(8'h11);
    push_rx(8'h22);
    axi_awvalid = 1'b1; axi_awaddr = 32'hC;
    axi_wvalid  = 1'b1; axi_wdata  = 32'h2;
    rx_in_valid = 1'b1; rx_in_data = 8'h33;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; rx_in_valid = 1'b0;
    check("clr_push_bvalid", {29'd0, axi_bvalid, axi_bresp}, 32'd4);
    rx_q.delete();
    m_ien = 1'b0;
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    rd_chk("stat_after_clear", 32'h8);

    push_rx(8'h77);
    rd_chk("bad_read", 32'h10);
    wr_chk("bad_write", 32'h14, 32'h13, 0, 1);
    rd_chk("stat_after_bad", 32'h8);

    // Reset with outstanding read and a half-complete write.
    wr_chk("tx_pre_reset", 32'h4, 32'h99, 0, 0);
    axi_arvalid = 1'b1; axi_araddr = 32'h8;
    axi_awvalid = 1'b1; axi_awaddr = 32'h4;
    tick();
    axi_arvalid = 1'b0; axi_awvalid = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rx_q.delete(); tx_q.delete(); m_ovr = 1'b0; m_ien = 1'b0;
    check("midrst_valids", {29'd0, axi_rvalid, axi_bvalid, tx_out_valid}, 32'd0);
    check("midrst_readys", {29'd0, axi_awready, axi_wready, axi_arready}, 32'd7);
    rd_chk("stat_after_midrst", 32'h8);

    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: repeat ($urandom_range(1, 4)) push_rx(8'($urandom));
        3: rd_chk("rnd_rx", 32'h0);
        4: rd_chk("rnd_stat", 32'h8);
        5: wr_chk("rnd_tx", 32'h4, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        6: begin
          if ($urandom_range(0, 2) == 0)
            wr_chk("rnd_ctrl", 32'hC, $urandom & 32'h13, $urandom_range(0, 3), $urandom_range(0, 3));
          else
            wr_chk("rnd_ctrl_ien", 32'hC, $urandom & 32'h10, 0, 0);
        end
        7: drain_tx();
        8: begin
          case ($urandom_range(0, 2))
            0: rd_chk("rnd_rd_tx", 32'h4);
            1: rd_chk("rnd_rd_ctrl", 32'hC);
            default: rd_chk("rnd_rd_bad", {$urandom_range(1, 255), 4'h0} & 32'hFFF0);
          endcase
        end
        default: begin
          case ($urandom_range(0, 2))
            0: wr_chk("rnd_wr_rx", 32'h0, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
            1: wr_chk("rnd_wr_stat", 32'h8, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
            default: wr_chk("rnd_wr_bad", 32'h100 | ($urandom & 32'hC), $urandom, 0, 0);
          endcase
        end
      endcase
    end
    drain_tx();
    rd_chk("stat_final", 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
